// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory controller.
package imem_pkg;

  typedef enum logic {
    StLoad,
    StRun
  } imem_state_e;

  localparam int unsigned FAULT_MISALIGN = 0;
  localparam int unsigned FAULT_RANGE    = 1;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/imem_byte_array.sv
// Byte-wide instruction storage with a big-endian 4-byte write port and a registered
// 4-byte read port. Both ports take word indices; contents are never reset.
module imem_byte_array #(
  parameter int unsigned DEPTH_BYTES = 16384,
  localparam int unsigned IdxW = $clog2(DEPTH_BYTES)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [IdxW-3:0] waddr,
  input  logic [31:0]     wdata,
  input  logic            re,
  input  logic [IdxW-3:0] raddr,
  output logic [31:0]     rdata
);

  logic [7:0] mem [DEPTH_BYTES] = '{default: 8'h00};

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        mem[{waddr, 2'(i)}] <= wdata[31-8*i -: 8];
      end
    end
  end

  // Read register only updates on an enabled read so a stalled response stays put.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= {mem[{raddr, 2'd0}], mem[{raddr, 2'd1}], mem[{raddr, 2'd2}], mem[{raddr, 2'd3}]};
    end
  end

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction memory: word loader in LOAD mode, one-cycle-latency fetch port in RUN mode
// with backpressure, flush and fault flagging.
module instr_mem_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_BYTES = 16384,
  parameter logic [31:0] NOP_WORD    = imem_pkg::NOP_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic              load_done,
  output logic              load_err,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  input  logic              flush,
  output logic              rsp_valid,
  output logic [31:0]       rsp_instr,
  output logic [1:0]        rsp_fault,
  input  logic              rsp_ready,
  output logic [31:0]       fetch_cnt
);

  localparam int unsigned       IdxW     = $clog2(DEPTH_BYTES);
  localparam logic [ADDR_W-1:0] LastWord = ADDR_W'(DEPTH_BYTES - 4);

  imem_state_e state_q, state_d;
  logic        load_err_q, load_err_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [1:0]  rsp_fault_q, rsp_fault_d;
  logic        rsp_data_q, rsp_data_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  logic        load_hs, load_bad, mem_we;
  logic        accept, mem_re;
  logic [1:0]  fetch_fault;
  logic [31:0] rd_data;

  always_comb begin
    state_d     = state_q;
    load_err_d  = load_err_q;
    rsp_valid_d = rsp_valid_q;
    rsp_fault_d = rsp_fault_q;
    rsp_data_d  = rsp_data_q;
    fetch_cnt_d = fetch_cnt_q;

    load_ready  = (state_q == StLoad);
    fetch_ready = (state_q == StRun) && !flush && (!rsp_valid_q || rsp_ready);

    load_hs  = load_valid && load_ready;
    load_bad = (load_addr[1:0] != 2'b00) || (load_addr > LastWord);
    mem_we   = load_hs && !load_bad;

    fetch_fault                 = '0;
    fetch_fault[FAULT_MISALIGN] = (fetch_addr[1:0] != 2'b00);
    fetch_fault[FAULT_RANGE]    = (fetch_addr > LastWord);

    accept = fetch_req && fetch_ready;
    // Faulted fetches never touch the array, so its index stays in bounds.
    mem_re = accept && (fetch_fault == 2'b00);

    if (state_q == StLoad && load_done) begin
      state_d = StRun;
    end
    if (load_hs && load_bad) begin
      load_err_d = 1'b1;
    end

    if (flush) begin
      rsp_valid_d = 1'b0;
    end else if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_fault_d = fetch_fault;
      rsp_data_d  = (fetch_fault == 2'b00);
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    if (accept && fetch_cnt_q != 32'hFFFF_FFFF) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StLoad;
      load_err_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 2'b00;
      rsp_data_q  <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      load_err_q  <= load_err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_fault_q <= rsp_fault_d;
      rsp_data_q  <= rsp_data_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  imem_byte_array #(
    .DEPTH_BYTES(DEPTH_BYTES)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .waddr(load_addr[IdxW-1:2]),
    .wdata(load_data),
    .re   (mem_re),
    .raddr(fetch_addr[IdxW-1:2]),
    .rdata(rd_data)
  );

  assign load_err  = load_err_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_fault = rsp_fault_q;
  assign rsp_instr = rsp_data_q ? rd_data : NOP_WORD;
  assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Directed bench for instr_mem_ctrl: loading, fetch, faults, backpressure, flush and reset.
module tb_instr_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid, load_ready, load_done, load_err;
  logic [31:0] load_addr, load_data;
  logic        fetch_req, fetch_ready, flush, rsp_valid, rsp_ready;
  logic [31:0] fetch_addr, rsp_instr, fetch_cnt;
  logic [1:0]  rsp_fault;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_cnt = 0;

  always #5 clk = ~clk;

  instr_mem_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .load_done  (load_done),
    .load_err   (load_err),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ready(fetch_ready),
    .flush      (flush),
    .rsp_valid  (rsp_valid),
    .rsp_instr  (rsp_instr),
    .rsp_fault  (rsp_fault),
    .rsp_ready  (rsp_ready),
    .fetch_cnt  (fetch_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] addr, input logic [31:0] data, input logic done);
    load_valid = 1'b1;
    load_addr  = addr;
    load_data  = data;
    load_done  = done;
    step();
    load_valid = 1'b0;
    load_done  = 1'b0;
  endtask

  // Single fetch with rsp_ready high; response is checked then consumed.
  task automatic fetch1(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                        input logic [1:0] fault);
    rsp_ready  = 1'b1;
    fetch_req  = 1'b1;
    fetch_addr = addr;
    step();
    fetch_req = 1'b0;
    exp_cnt++;
    check({tag, "_valid"}, rsp_valid, 1);
    check({tag, "_instr"}, rsp_instr, instr);
    check({tag, "_fault"}, rsp_fault, fault);
    step();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_instr"}, rsp_instr, 32'h0);
    check({tag, "_rsp_fault"}, rsp_fault, 0);
    check({tag, "_load_err"}, load_err, 0);
    check({tag, "_fetch_cnt"}, fetch_cnt, 0);
    check({tag, "_fetch_ready"}, fetch_ready, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    {load_valid, load_done, fetch_req, flush, rsp_ready} = '0;
    load_addr = '0; load_data = '0; fetch_addr = '0;
    #12;
    check_reset_state("rst");
    rst_n = 1'b1;
    #1;
    check("rst_load_ready", load_ready, 1);

    // Loads, including dropped misaligned and out-of-range ones.
    load_word(32'd200, 32'h2413_0005, 1'b0);
    load_word(32'd204, 32'h0E74_B820, 1'b0);
    check("load_err_clean", load_err, 0);
    load_word(32'd202, 32'hDEAD_BEEF, 1'b0);
    check("load_err_misalign", load_err, 1);
    load_word(32'd16384, 32'hFEED_FACE, 1'b0);
    check("load_err_sticky", load_err, 1);
    check("still_load", load_ready, 1);
    // load_done coinciding with the final load.
    load_word(32'd208, 32'h1122_3344, 1'b1);
    check("run_load_ready", load_ready, 0);

    // Back-to-back fetch at full throughput.
    rsp_ready  = 1'b1;
    fetch_req  = 1'b1;
    fetch_addr = 32'd200;
    #1;
    check("b2b_ready0", fetch_ready, 1);
    step();
    check("b2b_instr0", rsp_instr, 32'h2413_0005);
    check("b2b_fault0", rsp_fault, 0);
    fetch_addr = 32'd204;
    #1;
    check("b2b_ready1", fetch_ready, 1);
    step();
    fetch_req = 1'b0;
    check("b2b_instr1", rsp_instr, 32'h0E74_B820);
    check("b2b_valid1", rsp_valid, 1);
    check("b2b_fault1", rsp_fault, 0);
    check("b2b_cnt", fetch_cnt, 2);
    exp_cnt = 2;
    step();
    check("b2b_consumed", rsp_valid, 0);

    // Faults and range boundaries; dropped loads left memory untouched.
    fetch1("mis", 32'd201, 32'h0, 2'b01);
    fetch1("oor", 32'd16384, 32'h0, 2'b10);
    fetch1("both", 32'd16385, 32'h0, 2'b11);
    fetch1("top", 32'hFFFF_FFFC, 32'h0, 2'b10);
    fetch1("last", 32'd16380, 32'h0, 2'b00);
    fetch1("zero", 32'd0, 32'h0, 2'b00);
    fetch1("w200", 32'd200, 32'h2413_0005, 2'b00);
    fetch1("w208", 32'd208, 32'h1122_3344, 2'b00);
    check("fault_cnt", fetch_cnt, exp_cnt);

    // Backpressure.
    rsp_ready  = 1'b1;
    fetch_req  = 1'b1;
    fetch_addr = 32'd200;
    step();
    rsp_ready  = 1'b0;
    fetch_addr = 32'd204;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_ready", fetch_ready, 0);
      check("bp_valid", rsp_valid, 1);
      check("bp_instr", rsp_instr, 32'h2413_0005);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release", fetch_ready, 1);
    step();
    fetch_req = 1'b0;
    check("bp_next", rsp_instr, 32'h0E74_B820);
    exp_cnt += 2;
    check("bp_cnt", fetch_cnt, exp_cnt);
    step();

    // Flush refuses the same-cycle request and kills the response.
    fetch_req  = 1'b1;
    fetch_addr = 32'd200;
    step();
    flush      = 1'b1;
    fetch_addr = 32'd204;
    #1;
    check("flush_ready", fetch_ready, 0);
    step();
    flush     = 1'b0;
    fetch_req = 1'b0;
    exp_cnt++;
    check("flush_valid", rsp_valid, 0);
    check("flush_cnt", fetch_cnt, exp_cnt);

    // load_done and loads ignored in RUN.
    load_word(32'd200, 32'h5555_5555, 1'b1);
    check("run_ignore_ready", load_ready, 0);
    fetch1("run_ignore", 32'd200, 32'h2413_0005, 2'b00);

    // Reset with a response outstanding takes effect without a clock edge.
    fetch_req  = 1'b1;
    fetch_addr = 32'd204;
    step();
    fetch_req = 1'b0;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    check_reset_state("rst_async");
    step();
    rst_n = 1'b1;
    load_word(32'd300, 32'hCAFE_F00D, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_state("rst_midload");
    step();
    rst_n = 1'b1;
    #1;
    check("rst2_load_ready", load_ready, 1);
    load_word(32'd304, 32'h0BAD_C0DE, 1'b0);
    load_done = 1'b1;
    step();
    load_done = 1'b0;
    exp_cnt = 0;
    fetch1("keep300", 32'd300, 32'hCAFE_F00D, 2'b00);
    fetch1("new304", 32'd304, 32'h0BAD_C0DE, 2'b00);
    check("rst2_cnt", fetch_cnt, exp_cnt);
    check("rst2_load_err", load_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_mem_ctrl.md
# instr_mem_ctrl

Parametrised, synchronous-read instruction memory for the pipelined MIPS core. Programs are loaded one big-endian 32-bit word at a time through a load port while the block is in LOAD mode, then served to the IF stage through a fetch request/response handshake with one-cycle latency, backpressure and flush. Misaligned and out-of-range fetches are flagged and answered with a NOP. It replaces the combinational byte-array instruction memory that sits in front of IF.

## Interface
- `ADDR_W`, 32: address width, byte addresses.
- `DEPTH_BYTES`, 16384: memory size in bytes. Must be a multiple of 4 and a power of two.
- `NOP_WORD`, 32'h0000_0000: instruction returned on any fault.

- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `load_valid`, in, 1: load word offered.
- `load_ready`, out, 1: high only in LOAD.
- `load_addr`, in, ADDR_W: byte address of the word.
- `load_data`, in, 32: word. Bits [31:24] go to the lowest byte address.
- `load_done`, in, 1: one-cycle pulse that moves the block LOAD→RUN.
- `load_err`, out, 1: sticky flag. Set when a load is dropped.
- `fetch_req`, in, 1: fetch request (PC valid).
- `fetch_addr`, in, ADDR_W: PC.
- `fetch_ready`, out, 1: request accepted this cycle.
- `flush`, in, 1: discard the pending response. Refuse the same-cycle request.
- `rsp_valid`, out, 1: response valid.
- `rsp_instr`, out, 32: instruction.
- `rsp_fault`, out, 2: bit0 = misaligned, bit1 = out of range.
- `rsp_ready`, in, 1: IF stage consumes the response.
- `fetch_cnt`, out, 32: accepted fetches, saturating at 32'hFFFF_FFFF.

## Operation
- FSM has two states.
  - LOAD is the reset state. From LOAD it goes to RUN when `load_done` is high.
  - RUN has no exit except reset.
  - `load_done` has no effect in RUN.
- LOAD:
  - `load_ready`=1, `fetch_ready`=0.
  - A handshake (`load_valid`&`load_ready`) writes 4 bytes at `load_addr`..+3.
  - The load is dropped and `load_err` is set if either holds:
    - `load_addr[1:0]`≠0.
    - `load_addr` > DEPTH_BYTES-4.
- RUN:
  - `load_ready`=0.
  - `fetch_ready` = `!flush` & (`!rsp_valid` | `rsp_ready`).
  - On accept (`fetch_req`&`fetch_ready`), the response register loads next edge with:
    - `rsp_instr` = {mem[a],mem[a+1],mem[a+2],mem[a+3]}.
    - `rsp_fault` = 0.
    - `rsp_valid` = 1.
  - `fetch_cnt` increments on each accept.
- Fault handling on accept. Both fault bits may be set together; on any fault `rsp_instr`=NOP_WORD.
  - Misaligned (`fetch_addr[1:0]`≠0): `rsp_fault[0]`=1.
  - Out of range (`fetch_addr` > DEPTH_BYTES-4, compared at full ADDR_W; no wrap-around): `rsp_fault[1]`=1.
- Backpressure: while `rsp_valid`&`!rsp_ready`, the response register holds `rsp_instr` and `rsp_fault` stable.
- Consume without new accept: `rsp_valid`&`rsp_ready` with no accept drops `rsp_valid` to 0.
- Flush: `rsp_valid`←0 next edge regardless of `rsp_ready`. `flush` has priority over a same-cycle `rsp_ready`.
- Memory contents:
  - Zero at elaboration.
  - Not cleared by reset, so reset mid-load keeps words already written.
- Reset values:
  - FSM = LOAD.
  - `rsp_valid`=0, `rsp_instr`=NOP_WORD, `rsp_fault`=0.
  - `load_err`=0, `fetch_cnt`=0.
  - `load_ready`=1 once `rst_n` is high. `fetch_ready`=0.

## Timing
- Fetch latency is 1 cycle: accept at edge N, data valid after edge N.
- Throughput is 1 fetch/cycle when `rsp_ready` is held high.
- A load write is visible to any later fetch; RUN cannot start earlier than the cycle after the last load.
- A `load_done` pulse coinciding with a load handshake:
  - The write completes.
  - The state is RUN next cycle.
  - The first fetch can be accepted the cycle after that.
- `load_err` sets on the edge of the dropped handshake.
- Reset asserted mid-operation takes effect immediately (asynchronous). The outstanding response is lost.

## Structure
- Shared package `imem_pkg` holds:
  - The state enum (LOAD, RUN).
  - Fault bit indices `FAULT_MISALIGN`=0 and `FAULT_RANGE`=1.
  - The default `NOP_WORD` constant.
- One sub-module, `imem_byte_array`:
  - Byte-wide storage.
  - 4-byte big-endian write port.
  - Registered 4-byte read port.
- Top level holds the FSM, fault decode, response register and counter.

## Test plan
1. Load 0x24130005 @200, 0x0E74B820 @204, pulse `load_done`, fetch 200 then 204 back-to-back with `rsp_ready`=1 → `rsp_instr` 0x24130005 then 0x0E74B820 on consecutive cycles, `rsp_fault`=0, `fetch_cnt`=2.
2. RUN, fetch 201 → `rsp_instr`=0x00000000, `rsp_fault`=2'b01. Fetch 16384 → `rsp_fault`=2'b10. Fetch 16385 → 2'b11.
3. Fetch 200, hold `rsp_ready`=0 for 3 cycles with `fetch_req`=1 @204 → `fetch_ready`=0 and 0x24130005 stable for 3 cycles. After `rsp_ready`=1, 204 is accepted and 0x0E74B820 follows 1 cycle later.
4. Fetch 200, assert `flush` the next cycle while `fetch_req`=1 @204 → `rsp_valid`=0 the following cycle and 204 not accepted that cycle. `fetch_cnt` increments only for 200.
5. LOAD: load @202, then load @16384 → `load_err`=1, memory at 200 and 16380 unchanged (a later fetch returns 0). A subsequent load @208 still succeeds.
6. Load @300, assert `rst_n`=0 mid-load-sequence, release, load @304, `load_done` → fetch 300 returns the pre-reset word. `load_err`=0, `fetch_cnt` restarts at 0.
